ascii_tokenizer: RTL and testbench

//   Streaming successor to the combinational ASCII-to-code lookup in the expression datapath.

---
 rtl/ascii_tokenizer.sv | 225 ++++++++++++++++++++++
 tb/tb_ascii_tokenizer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_tokenizer.sv
// Streaming ASCII tokenizer: groups hex digits into DATA_W-bit operands and queues typed tokens.
// Optional feature macro UPPER_HEX_EN: accept 'A'-'F' as hex digits 10-15.
module ascii_tokenizer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        ascii_in,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [2:0]        tok_kind,
  output logic [DATA_W-1:0] tok_val,
  output logic              tok_last,
  output logic              err
);

  localparam int MAX_DIG = DATA_W / 4;
  localparam int CW      = $clog2(MAX_DIG + 1);
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] KIND_NUM  = 3'd0;
  localparam logic [2:0] KIND_LPAR = 3'd1;
  localparam logic [2:0] KIND_RPAR = 3'd2;
  localparam logic [2:0] KIND_MUL  = 3'd3;
  localparam logic [2:0] KIND_ADD  = 3'd4;
  localparam logic [2:0] KIND_SUB  = 3'd5;
  localparam logic [2:0] KIND_EQ   = 3'd6;

  typedef enum logic [1:0] {CLS_DIGIT, CLS_OP, CLS_SPACE, CLS_ILLEGAL} cls_t;
  typedef enum logic {ST_IDLE, ST_NUM} state_t;

  function automatic cls_t char_class(input logic [7:0] c);
    cls_t cls;
    if (c >= 8'h30 && c <= 8'h39) cls = CLS_DIGIT;
    else if (c >= 8'h61 && c <= 8'h66) cls = CLS_DIGIT;
`ifdef UPPER_HEX_EN
    else if (c >= 8'h41 && c <= 8'h46) cls = CLS_DIGIT;
`endif
    else if (c == 8'h28 || c == 8'h29 || c == 8'h2A || c == 8'h2B || c == 8'h2D || c == 8'h3D)
      cls = CLS_OP;
    else if (c == 8'h20) cls = CLS_SPACE;
    else cls = CLS_ILLEGAL;
    return cls;
  endfunction

  // Letters share the low nibble pattern 1..6 in both cases, so +9 yields 10..15.
  function automatic logic [3:0] digit_val(input logic [7:0] c);
    logic [3:0] d;
    if (c <= 8'h39) d = c[3:0];
    else d = c[3:0] + 4'd9;
    return d;
  endfunction

  function automatic logic [2:0] op_kind(input logic [7:0] c);
    logic [2:0] k;
    case (c)
      8'h28:   k = KIND_LPAR;
      8'h29:   k = KIND_RPAR;
      8'h2A:   k = KIND_MUL;
      8'h2B:   k = KIND_ADD;
      8'h2D:   k = KIND_SUB;
      8'h3D:   k = KIND_EQ;
      default: k = KIND_NUM;
    endcase
    return k;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(FIFO_DEPTH - 1)) n = '0;
    else n = p + PW'(1);
    return n;
  endfunction

  state_t            state_r, state_nx_s;
  cls_t              cls_s;
  logic [3:0]        dig_s;
  logic [2:0]        opk_s;
  logic              accept_s, pop_s;
  logic              push0_en_s, push1_en_s;
  logic [2:0]        push0_kind_s, push1_kind_s;
  logic [DATA_W-1:0] push0_val_s;
  logic [DATA_W-1:0] acc_r;
  logic [CW-1:0]     cnt_r;
  logic              err_r;
  logic [QW-1:0]     count_r;
  logic [PW-1:0]     rd_ptr_r, wr_ptr_r, wr_ptr1_s;
  logic [2:0]        kind_mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0] val_mem_r  [FIFO_DEPTH];

  assign cls_s     = char_class(ascii_in);
  assign dig_s     = digit_val(ascii_in);
  assign opk_s     = op_kind(ascii_in);
  assign in_ready  = (QW'(FIFO_DEPTH) - count_r) >= QW'(2);
  assign accept_s  = in_valid && in_ready;
  assign tok_valid = (count_r != '0);
  assign pop_s     = tok_valid && tok_ready;
  assign wr_ptr1_s = ptr_inc(wr_ptr_r);
  assign tok_kind  = tok_valid ? kind_mem_r[rd_ptr_r] : 3'd0;
  assign tok_val   = tok_valid ? val_mem_r[rd_ptr_r] : '0;
  assign tok_last  = tok_valid && (kind_mem_r[rd_ptr_r] == KIND_EQ);
  assign err       = err_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else state_r <= state_nx_s;
  end

  // FSM next state: digits open an operand, any terminator closes it
  always_comb begin
    state_nx_s = state_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: if (cls_s == CLS_DIGIT) state_nx_s = ST_NUM; else state_nx_s = ST_IDLE;
        ST_NUM:  if (cls_s == CLS_OP || cls_s == CLS_SPACE) state_nx_s = ST_IDLE;
                 else state_nx_s = ST_NUM;
        default: state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // FSM outputs: up to two FIFO writes per accepted char (operand then operator)
  always_comb begin
    push0_en_s   = 1'b0;
    push1_en_s   = 1'b0;
    push0_kind_s = KIND_NUM;
    push0_val_s  = '0;
    push1_kind_s = KIND_NUM;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (cls_s == CLS_OP) begin
            push0_en_s   = 1'b1;
            push0_kind_s = opk_s;
          end else begin
            push0_en_s = 1'b0;
          end
        end
        ST_NUM: begin
          if (cls_s == CLS_OP) begin
            push0_en_s   = 1'b1;
            push0_val_s  = acc_r;
            push1_en_s   = 1'b1;
            push1_kind_s = opk_s;
          end else if (cls_s == CLS_SPACE) begin
            push0_en_s  = 1'b1;
            push0_val_s = acc_r;
          end else begin
            push0_en_s = 1'b0;
          end
        end
        default: push0_en_s = 1'b0;
      endcase
    end else begin
      push0_en_s = 1'b0;
    end
  end

  // Operand accumulator, digit count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (accept_s) begin
      case (cls_s)
        CLS_DIGIT: begin
          if (state_r == ST_IDLE) begin
            acc_r <= {{(DATA_W-4){1'b0}}, dig_s};
            cnt_r <= CW'(1);
          end else if (cnt_r < CW'(MAX_DIG)) begin
            acc_r <= {acc_r[DATA_W-5:0], dig_s};
            cnt_r <= cnt_r + CW'(1);
          end else begin
            err_r <= 1'b1;
          end
        end
        CLS_OP, CLS_SPACE: begin
          acc_r <= '0;
          cnt_r <= '0;
        end
        CLS_ILLEGAL: err_r <= 1'b1;
        default:     err_r <= err_r;
      endcase
    end else begin
      err_r <= err_r;
    end
  end

  // Token FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        kind_mem_r[i] <= 3'd0;
        val_mem_r[i]  <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push0_en_s) begin
        kind_mem_r[wr_ptr_r] <= push0_kind_s;
        val_mem_r[wr_ptr_r]  <= push0_val_s;
      end
      if (push1_en_s) begin
        kind_mem_r[wr_ptr1_s] <= push1_kind_s;
        val_mem_r[wr_ptr1_s]  <= '0;
      end
      if (push1_en_s) wr_ptr_r <= ptr_inc(wr_ptr1_s);
      else if (push0_en_s) wr_ptr_r <= wr_ptr1_s;
      else wr_ptr_r <= wr_ptr_r;
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      else rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + QW'(push0_en_s) + QW'(push1_en_s) - QW'(pop_s);
    end
  end

endmodule

// File: tb/tb_ascii_tokenizer.sv
// Self-checking bench for ascii_tokenizer: directed scenarios plus randomized traffic against a token-queue model.
module tb_ascii_tokenizer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int MAXD   = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        ascii_in = 8'h00;
  logic              tok_valid;
  logic              tok_ready = 1'b0;
  logic [2:0]        tok_kind;
  logic [DATA_W-1:0] tok_val;
  logic              tok_last;
  logic              err;

  ascii_tokenizer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ascii_in(ascii_in), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_val(tok_val), .tok_last(tok_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int v; } tok_t;
  tok_t q[$];
  int   ndig = 0;
  int   acc  = 0;
  bit   merr = 1'b0;
  int   log_k[$];
  int   log_v[$];
  int   exp_k[$];
  int   exp_v[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input byte c);
    string lo = "0123456789abcdef";
    string up = "ABCDEF";
    for (int i = 0; i < 16; i++) if (lo[i] == c) return i;
`ifdef UPPER_HEX_EN
    for (int i = 0; i < 6; i++) if (up[i] == c) return 10 + i;
`else
    if (up.len() == 0) return -1;
`endif
    return -1;
  endfunction

  function automatic int op_of(input byte c);
    string ops = "()*+-=";
    for (int i = 0; i < 6; i++) if (ops[i] == c) return i + 1;
    return 0;
  endfunction

  task automatic model_char(input byte c);
    int d = digit_of(c);
    int op = op_of(c);
    if (d >= 0) begin
      if (ndig == 0) begin acc = d; ndig = 1; end
      else if (ndig < MAXD) begin acc = acc * 16 + d; ndig++; end
      else merr = 1'b1;
    end else if (op > 0 || c == 8'h20) begin
      if (ndig > 0) q.push_back('{0, acc});
      if (op > 0) q.push_back('{op, 0});
      ndig = 0;
      acc = 0;
    end else begin
      merr = 1'b1;
    end
  endtask

  // One clock: present inputs, let the edge happen, advance the model identically.
  task automatic cycle(input bit v, input byte c, input bit tr, output bit accepted);
    bit rdy;
    in_valid = v;
    ascii_in = c;
    tok_ready = tr;
    @(posedge clk);
    rdy = (DEPTH - q.size()) >= 2;
    if (tr && q.size() > 0) void'(q.pop_front());
    accepted = v && rdy;
    if (accepted) model_char(c);
    #1;
  endtask

  task automatic send(input byte c, input bit tr);
    bit a = 1'b0;
    int budget = 0;
    while (!a) begin
      cycle(1'b1, c, tr, a);
      budget++;
      if (!a && budget > 100) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input bit tr);
    for (int i = 0; i < s.len(); i++) send(s[i], tr);
  endtask

  task automatic drain();
    bit a;
    int budget = 0;
    while (q.size() > 0 && budget < 200) begin
      cycle(1'b0, 8'h00, 1'b1, a);
      budget++;
    end
    cycle(1'b0, 8'h00, 1'b1, a);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_k.size(), exp_k.size());
    for (int i = 0; i < exp_k.size() && i < log_k.size(); i++) begin
      chk({name, "_kind"}, log_k[i], exp_k[i]);
      chk({name, "_val"}, log_v[i], exp_v[i]);
    end
    log_k.delete(); log_v.delete(); exp_k.delete(); exp_v.delete();
  endtask

  task automatic expect_tok(input int k, input int v);
    exp_k.push_back(k);
    exp_v.push_back(v);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    tok_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_tok_valid", tok_valid, 0);
    chk("rst_tok_kind", tok_kind, 0);
    chk("rst_tok_val", tok_val, 0);
    chk("rst_tok_last", tok_last, 0);
    chk("rst_err", err, 0);
    q.delete(); ndig = 0; acc = 0; merr = 1'b0;
    log_k.delete(); log_v.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Every cycle out of reset: DUT outputs against the model's queue head and state
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tok_valid", tok_valid, q.size() != 0);
      chk("in_ready", in_ready, (DEPTH - q.size()) >= 2);
      chk("err", err, merr);
      if (q.size() > 0) begin
        chk("tok_kind", tok_kind, q[0].k);
        chk("tok_val", tok_val, q[0].v);
        chk("tok_last", tok_last, q[0].k == 6);
        if (tok_ready) begin
          log_k.push_back(tok_kind);
          log_v.push_back(tok_val);
        end
      end
    end
  end

  initial begin
    bit a;
    string alpha = "0123456789abcdef()*+-= gA";
    #3;
    do_reset();

    send_str("1f+2=", 1'b1);
    drain();
    expect_tok(0, 'h1f); expect_tok(4, 0); expect_tok(0, 2); expect_tok(6, 0);
    check_log("t1");
    chk("t1_err", err, 0);

    send_str("(a*", 1'b0);
    cycle(1'b0, 8'h00, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, a);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_head_held", tok_kind, 1);
    send_str("b)-3=", 1'b1);
    drain();
    expect_tok(1, 0); expect_tok(0, 'ha); expect_tok(3, 0); expect_tok(0, 'hb);
    expect_tok(2, 0); expect_tok(5, 0); expect_tok(0, 3); expect_tok(6, 0);
    check_log("t2");

    send_str("12345+", 1'b1);
    drain();
    expect_tok(0, 'h1234); expect_tok(4, 0);
    check_log("t3");
    chk("t3_err", err, 1);

    do_reset();
    send_str("7 8=", 1'b1);
    drain();
    expect_tok(0, 7); expect_tok(0, 8); expect_tok(6, 0);
    check_log("t4a");
    chk("t4a_err", err, 0);
    send_str("7g=", 1'b1);
    drain();
    expect_tok(0, 7); expect_tok(6, 0);
    check_log("t4b");
    chk("t4b_err", err, 1);

    do_reset();
    send_str("3F=", 1'b1);
    drain();
`ifdef UPPER_HEX_EN
    expect_tok(0, 'h3f); expect_tok(6, 0);
    check_log("t5");
    chk("t5_err", err, 0);
`else
    expect_tok(0, 3); expect_tok(6, 0);
    check_log("t5");
    chk("t5_err", err, 1);
`endif

    do_reset();
    send_str("ab", 1'b1);
    do_reset();
    send_str("5=", 1'b1);
    drain();
    expect_tok(0, 5); expect_tok(6, 0);
    check_log("t6");

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1), alpha[$urandom_range(0, alpha.len() - 1)],
            $urandom_range(0, 9) < 7, a);
    end
    send("=", 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
